instruction_fetch_unit: RTL

- Sequences the instruction memory for the core.
- Owns the fetch PC and issues word-aligned read requests over a req/gnt + rvalid interface.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects by flushing the buffer and discarding in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_MISALIGN_TRAP_EN adds a fault bit to each buffered fetch entry.
package riscv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

    typedef struct packed {
`ifdef FETCH_MISALIGN_TRAP_EN
        logic            fault;
`endif
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: shift-style FIFO whose head is always slot 0, so the head
// comes straight from a flop. Flush is synchronous and may coincide with a push.
module fetch_fifo #(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic             do_pop;
    logic [CW-1:0]    wr_idx;

    assign do_pop     = pop && !flush && (count != '0);
    assign wr_idx     = flush ? '0 : count - CW'(do_pop);
    assign head_data  = slots[0];
    assign head_valid = (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (flush)
            count <= CW'(push);
        else
            count <= count + CW'(push) - CW'(do_pop);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [WIDTH-1:0] shift_in;
        if (g < DEPTH-1) begin : g_mid
            assign shift_in = slots[g+1];
        end else begin : g_tail
            assign shift_in = slots[g];
        end

        // A push into the slot vacated by a simultaneous pop wins over the shift.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                slots[g] <= RESET_VAL;
            else if (push && wr_idx == CW'(g))
                slots[g] <= push_data;
            else if (do_pop)
                slots[g] <= shift_in;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch controller: owns fetch/response PCs, request credit and stale-response discard.
// FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a faulting entry and halts fetch.
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        instr_fault,
`endif
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [$bits(fetch_entry_t)-1:0] RESET_ENTRY =
        $bits(fetch_entry_t)'({RESET_VECTOR, {XLEN{1'b0}}});

    fetch_state_e    state;
    logic [XLEN-1:0] req_pc, resp_pc, redirect_base;
    logic [CW-1:0]   outstanding, discard_cnt, fifo_count;
    logic [CW:0]     credit_used;
    logic            xfer, accept, push, pop, halted, head_valid;
    fetch_entry_t    push_entry, head;

    assign redirect_base = redirect_pc & ~XLEN'(INSTR_BYTES-1);

    // A pop this cycle frees its slot, which keeps 1 instr/cycle with depth 2.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - (CW+1)'(pop);
    assign mem_req     = (state == RUN) && !redirect_valid && !halted &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign mem_addr    = req_pc;
    assign xfer        = mem_req && mem_gnt;

    assign accept = mem_rvalid && (discard_cnt == '0) && !redirect_valid;
    assign pop    = head_valid && instr_ready && !redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halted <= 1'b0;
        else if (redirect_valid)
            halted <= misaligned;
    end
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = resp_pc;
        push_entry.data = mem_rdata;
        push            = accept;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned) begin
            push_entry.pc    = redirect_pc;
            push_entry.data  = '0;
            push_entry.fault = 1'b1;
            push             = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            req_pc      <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= RUN;
            outstanding <= outstanding + CW'(xfer) - CW'(mem_rvalid);
            if (redirect_valid) begin
                // Everything still in flight is stale, including a word landing now.
                req_pc      <= redirect_base;
                resp_pc     <= redirect_base;
                discard_cnt <= outstanding - CW'(mem_rvalid);
            end else begin
                if (xfer)
                    req_pc <= next_pc(req_pc);
                if (accept)
                    resp_pc <= next_pc(resp_pc);
                if (mem_rvalid && discard_cnt != '0)
                    discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH     ($bits(fetch_entry_t)),
        .DEPTH     (FIFO_DEPTH),
        .RESET_VAL (RESET_ENTRY)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_data  (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign instr_valid = head_valid;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign instr_fault = head.fault;
`endif

endmodule
